// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data RAM responder: width codes, FSM states.
package mem_defs;

    localparam int MEM_WORD_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_ram_responder_if.sv
// Load/store request and completion bundle between CPU memory stage and RAM.
interface data_ram_responder_if
    import mem_defs::*;
#(
    parameter int ADDR_WIDTH = 8
);
    logic                      load;
    logic                      store;
    logic [ADDR_WIDTH-1:0]     address;
    logic [MEM_WORD_WIDTH-1:0] write_data;
    logic [2:0]                func3;
    logic [MEM_WORD_WIDTH-1:0] read_data;
    logic                      mem_done;
    logic                      busy;
    logic                      misaligned;

    modport master (
        output load, store, address, write_data, func3,
        input  read_data, mem_done, busy, misaligned
    );

    modport slave (
        input  load, store, address, write_data, func3,
        output read_data, mem_done, busy, misaligned
    );
endinterface

// File: rtl/data_ram_responder_mem_align.sv
// Byte-lane merge for stores, lane extract and extension for loads,
// and rejection of misaligned or undefined width codes.
module mem_align
    import mem_defs::*;
(
    input  logic [1:0]                addr_lo,
    input  logic [2:0]                func3,
    input  logic [MEM_WORD_WIDTH-1:0] wdata,
    input  logic [MEM_WORD_WIDTH-1:0] old_word,
    output logic [MEM_WORD_WIDTH-1:0] new_word,
    output logic [MEM_WORD_WIDTH-1:0] load_data,
    output logic                      err
);
    logic [3:0]                mask;
    logic [MEM_WORD_WIDTH-1:0] wlane;
    logic [MEM_WORD_WIDTH-1:0] shifted;

    always_comb begin
        err       = 1'b0;
        mask      = 4'b0000;
        wlane     = '0;
        load_data = '0;
        shifted   = old_word >> {addr_lo, 3'b000};
        case (func3)
            F3_B, F3_BU: begin
                mask  = 4'b0001 << addr_lo;
                wlane = {4{wdata[7:0]}};
                load_data = {{24{shifted[7] & ~func3[2]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                err   = addr_lo[0];
                mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                load_data = {{16{shifted[15] & ~func3[2]}}, shifted[15:0]};
            end
            F3_W: begin
                err       = |addr_lo;
                mask      = 4'b1111;
                wlane     = wdata;
                load_data = old_word;
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) new_word[i*8 +: 8] = wlane[i*8 +: 8];
        end
    end
endmodule

// File: rtl/data_ram_responder.sv
// Memory-stage responder: accepts one load/store, waits LATENCY cycles,
// completes it against the word array and pulses mem_done.
module data_ram_responder
    import mem_defs::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input logic               clock,
    input logic               reset,
    data_ram_responder_if.slave bus
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [MEM_WORD_WIDTH-1:0] storage [DEPTH];

    state_t                    state;
    state_t                    state_next;
    logic                      accept;
    logic                      fire;
    logic [CW-1:0]             cnt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [MEM_WORD_WIDTH-1:0] wdata_q;
    logic [2:0]                f3_q;
    logic                      store_q;
    logic                      err_q;
    logic [MEM_WORD_WIDTH-1:0] rdata_q;
    logic [IDXW-1:0]           idx;
    logic [MEM_WORD_WIDTH-1:0] old_word;
    logic [MEM_WORD_WIDTH-1:0] new_word;
    logic [MEM_WORD_WIDTH-1:0] load_data;
    logic                      err;

    assign idx      = IDXW'(addr_q >> 2);
    assign old_word = storage[idx];

    mem_align u_align (
        .addr_lo   (addr_q[1:0]),
        .func3     (f3_q),
        .wdata     (wdata_q),
        .old_word  (old_word),
        .new_word  (new_word),
        .load_data (load_data),
        .err       (err)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.load | bus.store) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CW'(LATENCY - 1)) begin
                    fire       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
                f3_q    <= bus.func3;
                store_q <= bus.store;
            end else if (state == ST_WAIT && !fire) begin
                cnt <= cnt + 1'b1;
            end
            if (fire) begin
                err_q <= err;
                if (err)           rdata_q <= '0;
                else if (!store_q) rdata_q <= load_data;
            end
        end
    end

    // Contents survive reset; only a completing, accepted store writes.
    always_ff @(posedge clock) begin
        if (!reset && fire && store_q && !err) storage[idx] <= new_word;
    end

    assign bus.read_data  = rdata_q;
    assign bus.mem_done   = (state == ST_DONE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.misaligned = (state == ST_DONE) & err_q;
endmodule
